// File: rtl/comparator_nin_pipe.sv
`default_nettype none
// ============================================================================
// Module      : comparator_nin_pipe
// Description : Pipelined N-input unsigned maximum finder (winner-take-all).
//               Optional minimum-threshold gating via COMPARATOR_THRESHOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_nin_pipe #(
    parameter  int P_WIDTH  = 22,
    parameter  int P_INPUTS = 8,
    localparam int C_LEVELS = $clog2(P_INPUTS),
    localparam int C_IDX_W  = (C_LEVELS > 1) ? C_LEVELS : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [P_INPUTS*P_WIDTH-1:0]   i_data,
`ifdef COMPARATOR_THRESHOLD_EN
    input  logic [P_WIDTH-1:0]            i_threshold,
`endif
    output logic                          o_valid,
    output logic [P_WIDTH-1:0]            o_result,
    output logic [P_INPUTS-1:0]           o_index,
    output logic [C_IDX_W-1:0]            o_index_bin,
    output logic                          o_tie
);

    // Tree nodes of all stages packed back to back; stage s starts at N - (N >> s).
    localparam int C_NODES = P_INPUTS - 1;
    localparam int C_ROOT  = P_INPUTS - 2;

    logic [P_WIDTH-1:0]  r_val [C_NODES];
    logic [P_INPUTS-1:0] r_oh  [C_NODES];
    logic [C_IDX_W-1:0]  r_bin [C_NODES];
    logic                r_tie [C_NODES];
    logic                r_vld [C_LEVELS];
`ifdef COMPARATOR_THRESHOLD_EN
    logic [P_WIDTH-1:0]  r_thr [C_LEVELS];
`endif

    for (genvar s = 0; s < C_LEVELS; s++) begin : g_stage
        localparam int C_OFF = P_INPUTS - (P_INPUTS >> s);
        localparam int C_CNT = P_INPUTS >> (s + 1);

        logic w_in_vld;
`ifdef COMPARATOR_THRESHOLD_EN
        logic [P_WIDTH-1:0] w_in_thr;
`endif

        if (s == 0) begin : g_first
            assign w_in_vld = i_valid;
`ifdef COMPARATOR_THRESHOLD_EN
            assign w_in_thr = i_threshold;
`endif
        end else begin : g_next
            assign w_in_vld = r_vld[s-1];
`ifdef COMPARATOR_THRESHOLD_EN
            assign w_in_thr = r_thr[s-1];
`endif
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld[s] <= 1'b0;
            end else begin
                r_vld[s] <= w_in_vld;
            end
        end

`ifdef COMPARATOR_THRESHOLD_EN
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_thr[s] <= '0;
            end else if (w_in_vld) begin
                r_thr[s] <= w_in_thr;
            end
        end
`endif

        for (genvar j = 0; j < C_CNT; j++) begin : g_node
            logic [P_WIDTH-1:0]  w_a_val, w_b_val;
            logic [P_INPUTS-1:0] w_a_oh,  w_b_oh;
            logic [C_IDX_W-1:0]  w_a_bin, w_b_bin;
            logic                w_a_tie, w_b_tie;
            logic                w_take_b, w_eq;

            if (s == 0) begin : g_leaf
                assign w_a_val = i_data[(2*j)*P_WIDTH +: P_WIDTH];
                assign w_b_val = i_data[(2*j+1)*P_WIDTH +: P_WIDTH];
                assign w_a_oh  = {{(P_INPUTS-1){1'b0}}, 1'b1} << (2*j);
                assign w_b_oh  = {{(P_INPUTS-1){1'b0}}, 1'b1} << (2*j+1);
                assign w_a_bin = C_IDX_W'(2*j);
                assign w_b_bin = C_IDX_W'(2*j+1);
                assign w_a_tie = 1'b0;
                assign w_b_tie = 1'b0;
            end else begin : g_tree
                localparam int C_PREV = P_INPUTS - (P_INPUTS >> (s - 1));
                assign w_a_val = r_val[C_PREV + 2*j];
                assign w_b_val = r_val[C_PREV + 2*j + 1];
                assign w_a_oh  = r_oh [C_PREV + 2*j];
                assign w_b_oh  = r_oh [C_PREV + 2*j + 1];
                assign w_a_bin = r_bin[C_PREV + 2*j];
                assign w_b_bin = r_bin[C_PREV + 2*j + 1];
                assign w_a_tie = r_tie[C_PREV + 2*j];
                assign w_b_tie = r_tie[C_PREV + 2*j + 1];
            end

            // On equality the lower-index node is kept and the tie is flagged.
            assign w_take_b = (w_b_val > w_a_val);
            assign w_eq     = (w_b_val == w_a_val);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_val[C_OFF+j] <= '0;
                    r_oh [C_OFF+j] <= '0;
                    r_bin[C_OFF+j] <= '0;
                    r_tie[C_OFF+j] <= 1'b0;
                end else if (w_in_vld) begin
                    r_val[C_OFF+j] <= w_take_b ? w_b_val : w_a_val;
                    r_oh [C_OFF+j] <= w_take_b ? w_b_oh  : w_a_oh;
                    r_bin[C_OFF+j] <= w_take_b ? w_b_bin : w_a_bin;
                    r_tie[C_OFF+j] <= w_eq | (w_take_b ? w_b_tie : w_a_tie);
                end
            end
        end
    end

    assign o_valid  = r_vld[C_LEVELS-1];
    assign o_result = r_val[C_ROOT];

`ifdef COMPARATOR_THRESHOLD_EN
    // A maximum below threshold still reports its value but names no winner.
    logic w_below;
    assign w_below     = (r_val[C_ROOT] < r_thr[C_LEVELS-1]);
    assign o_index     = w_below ? '0   : r_oh[C_ROOT];
    assign o_index_bin = w_below ? '0   : r_bin[C_ROOT];
    assign o_tie       = w_below ? 1'b0 : r_tie[C_ROOT];
`else
    assign o_index     = r_oh[C_ROOT];
    assign o_index_bin = r_bin[C_ROOT];
    assign o_tie       = r_tie[C_ROOT];
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparator_nin_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_nin_pipe
// Description : Directed + random scoreboard bench for comparator_nin_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_nin_pipe;
    localparam int W   = 22;
    localparam int N   = 8;
    localparam int IW  = $clog2(N);
    localparam int LAT = $clog2(N);

    typedef int vec_t [N];
    typedef struct {
        logic [W-1:0]  val;
        logic [N-1:0]  oh;
        logic [IW-1:0] bin;
        logic          tie;
        int            due;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [N*W-1:0] data = '0;
`ifdef COMPARATOR_THRESHOLD_EN
    logic [W-1:0]  thr   = '0;
`endif
    logic          o_valid;
    logic [W-1:0]  o_result;
    logic [N-1:0]  o_index;
    logic [IW-1:0] o_index_bin;
    logic          o_tie;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last;

    comparator_nin_pipe #(.P_WIDTH(W), .P_INPUTS(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_data      (data),
`ifdef COMPARATOR_THRESHOLD_EN
        .i_threshold (thr),
`endif
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_index     (o_index),
        .o_index_bin (o_index_bin),
        .o_tie       (o_tie)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: pops the scoreboard when an entry is due, else expects hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_valid", 64'(o_valid), 64'(0));
            chk("rst_result", 64'(o_result), 64'(0));
            chk("rst_index", 64'(o_index), 64'(0));
            chk("rst_index_bin", 64'(o_index_bin), 64'(0));
            chk("rst_tie", 64'(o_tie), 64'(0));
            last = '{'0, '0, '0, 1'b0, 0};
        end else if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out_valid", 64'(o_valid), 64'(1));
            chk("out_result", 64'(o_result), 64'(e.val));
            chk("out_index", 64'(o_index), 64'(e.oh));
            chk("out_index_bin", 64'(o_index_bin), 64'(e.bin));
            chk("out_tie", 64'(o_tie), 64'(e.tie));
            last = e;
        end else begin
            chk("idle_valid", 64'(o_valid), 64'(0));
            chk("hold_result", 64'(o_result), 64'(last.val));
            chk("hold_index", 64'(o_index), 64'(last.oh));
            chk("hold_index_bin", 64'(o_index_bin), 64'(last.bin));
            chk("hold_tie", 64'(o_tie), 64'(last.tie));
        end
    end

    task automatic rand_data();
        for (int k = 0; k < N; k++) data[k*W +: W] = W'($urandom);
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        int   best = 0;
        int   cnt  = 0;
        for (int k = 0; k < N; k++) begin
            data[k*W +: W] = W'(v[k]);
            if (v[k] > v[best]) best = k;
        end
        for (int k = 0; k < N; k++) if (v[k] == v[best]) cnt++;
        e.val = W'(v[best]);
        e.oh  = N'(1) << best;
        e.bin = IW'(best);
        e.tie = (cnt > 1);
        e.due = cyc + LAT;
`ifdef COMPARATOR_THRESHOLD_EN
        if (v[best] < int'(thr)) begin
            e.oh  = '0;
            e.bin = '0;
            e.tie = 1'b0;
        end
`endif
        valid = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            rand_data();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t v;
        // Reset held with valid high and changing data
        rst_n = 1'b0;
        valid = 1'b1;
        repeat (3) begin
            rand_data();
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        idle(2);

        // Unique maximum at input 0
        send('{3, 2, 1, 0, 0, 0, 0, 0});
        idle(4);

        // Ties and a single winner among near-equal values
        send('{12, 12, 11, 12, 11, 10, 0, 0});
        send('{33, 33, 33, 33, 34, 33, 33, 33});
        idle(4);

        // Back-to-back winners at 7, 5, 3, 1 followed by bubbles
        send('{1, 2, 3, 4, 5, 6, 7, 9});
        send('{0, 0, 0, 0, 0, 50, 0, 49});
        send('{8, 8, 8, 9, 8, 8, 8, 8});
        send('{0, 100, 0, 0, 0, 0, 0, 0});
        idle(5);

        // All zero and all maximum-value inputs
        send('{0, 0, 0, 0, 0, 0, 0, 0});
        for (int k = 0; k < N; k++) v[k] = (1 << W) - 1;
        send(v);
        idle(4);

        // Reset one cycle after launching two vectors
        send('{5, 9, 1, 1, 1, 1, 1, 1});
        send('{1, 1, 1, 1, 1, 1, 1, 77});
        rst_n = 1'b0;
        valid = 1'b0;
        q.delete();
        idle(2);
        rst_n = 1'b1;
        send('{4, 4, 4, 4, 4, 4, 6, 4});
        idle(5);

`ifdef COMPARATOR_THRESHOLD_EN
        thr = W'(20);
        send('{21, 20, 21, 0, 0, 0, 0, 0});
        thr = W'(22);
        send('{21, 20, 21, 0, 0, 0, 0, 0});
        thr = W'(21);
        send('{21, 20, 21, 0, 0, 0, 0, 0});
        idle(4);
        thr = '0;
`endif

        // Random traffic with bubbles; small values to provoke ties
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < N; k++)
                    v[k] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                                       : int'($urandom_range(0, (1 << W) - 1));
                send(v);
            end else begin
                idle(1);
            end
        end
        idle(LAT + 3);

        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
